mdu_hilo: RTL and testbench

Iterative multiply/divide unit with HI/LO result registers for the MIPS pipeline, parametrised in operand width. It sits beside the EX stage: EX issues MULT/MULTU/DIV/DIVU with the rs/rt operands, the unit runs a fixed-latency shift-based sequence, and results land in HI/LO for later MFHI/MFLO reads. The unit raises `busy` so the hazard logic can stall dependent MFHI/MFLO/MTHI/MTLO and further multiply/divide ops. It accepts a flush so an overflow exception or branch squash can abort an in-flight operation.

---
 rtl/mdu_pkg.sv | 26 ++
 rtl/mdu_sign_fix.sv | 57 +++++
 rtl/mdu_hilo.sv | 160 ++++++++++++++++
 tb/tb_mdu_hilo.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit.
// mdu_op_t uses the same 2-bit encodings as the decode control unit.
package mdu_pkg;

  typedef enum logic [1:0] {
    MULT  = 2'b00,
    MULTU = 2'b01,
    DIV   = 2'b10,
    DIVU  = 2'b11
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } mdu_state_t;

  function automatic logic op_is_div(input mdu_op_t o);
    return (o == DIV) || (o == DIVU);
  endfunction

  function automatic logic op_is_signed(input mdu_op_t o);
    return (o == MULT) || (o == DIV);
  endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// Combinational sign helpers for mdu_hilo.
// Input side : magnitudes and sign flags of the a/b operands.
// Output side: sign correction of the raw unsigned result.
//   a, b            operands as issued
//   is_signed       operands are two's complement
//   a_mag, b_mag    |a|, |b| (unchanged when unsigned)
//   a_neg, b_neg    operand sign bits (0 when unsigned)
//   is_div          raw result is quotient/remainder, not a product
//   neg_main        negate product (multiply) or quotient (divide)
//   neg_rem         negate remainder (divide only)
//   res_hi, res_lo  raw unsigned result
//   fix_hi, fix_lo  corrected values for HI/LO
module mdu_sign_fix
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  output logic [WIDTH-1:0] a_mag,
  output logic [WIDTH-1:0] b_mag,
  output logic             a_neg,
  output logic             b_neg,
  input  logic             is_div,
  input  logic             neg_main,
  input  logic             neg_rem,
  input  logic [WIDTH-1:0] res_hi,
  input  logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] fix_hi,
  output logic [WIDTH-1:0] fix_lo
);

  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_neg;

  always_comb begin
    a_neg = is_signed & a[WIDTH-1];
    b_neg = is_signed & b[WIDTH-1];
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;
  end

  always_comb begin
    prod     = {res_hi, res_lo};
    prod_neg = -prod;
    fix_hi   = res_hi;
    fix_lo   = res_lo;
    if (is_div) begin
      fix_lo = neg_main ? -res_lo : res_lo;
      fix_hi = neg_rem  ? -res_hi : res_hi;
    end else if (neg_main) begin
      {fix_hi, fix_lo} = prod_neg;
    end
  end

endmodule

// File: rtl/mdu_hilo.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// One result bit per cycle: WIDTH RUN cycles then one FIX cycle.
//   clk, rst          clock, synchronous active-high reset
//   start, op, a, b   issue MULT/MULTU/DIV/DIVU (sampled in IDLE only)
//   flush             abort the in-flight operation, no HI/LO write
//   mthi, mtlo, wdata direct HI/LO writes (IDLE only)
//   busy              operation in flight (registered)
//   done              one-cycle pulse when HI/LO take a result
//   hi, lo            HI/LO registers
module mdu_hilo
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  mdu_state_t state, state_n;
  mdu_op_t    op_in, op_q;
  logic [CW-1:0]    cnt;
  // Multiply: hi_acc:lo_acc is the partial product, lo_acc shifting out multiplier bits.
  // Divide:   hi_acc is the partial remainder, lo_acc shifts dividend out / quotient in.
  logic [WIDTH-1:0] hi_acc, lo_acc, hi_acc_n, lo_acc_n;
  logic [WIDTH-1:0] opnd;
  logic             neg_main, neg_rem;

  logic [WIDTH-1:0] a_mag, b_mag, fix_hi, fix_lo;
  logic             a_neg, b_neg;
  logic             start_ok, write_res;

  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   div_shift, div_diff;

  assign op_in = mdu_op_t'(op);

  mdu_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
    .a         (a),
    .b         (b),
    .is_signed (op_is_signed(op_in)),
    .a_mag     (a_mag),
    .b_mag     (b_mag),
    .a_neg     (a_neg),
    .b_neg     (b_neg),
    .is_div    (op_is_div(op_q)),
    .neg_main  (neg_main),
    .neg_rem   (neg_rem),
    .res_hi    (hi_acc),
    .res_lo    (lo_acc),
    .fix_hi    (fix_hi),
    .fix_lo    (fix_lo)
  );

  always_comb begin
    state_n   = state;
    start_ok  = 1'b0;
    write_res = 1'b0;
    case (state)
      IDLE: begin
        if (start && !flush) begin
          start_ok = 1'b1;
          state_n  = RUN;
        end
      end
      RUN: begin
        if (flush)                 state_n = IDLE;
        else if (cnt == CNT_LAST)  state_n = FIX;
      end
      FIX: begin
        write_res = !flush;
        state_n   = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // One iteration of shift-add multiply or restoring divide.
  always_comb begin
    add_sum   = {1'b0, hi_acc} + (lo_acc[0] ? {1'b0, opnd} : '0);
    div_shift = {hi_acc, lo_acc[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd};
    if (op_is_div(op_q)) begin
      // Partial remainder stays below the divisor, so a borrow shows in bit WIDTH.
      hi_acc_n = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
      lo_acc_n = {lo_acc[WIDTH-2:0], ~div_diff[WIDTH]};
    end else begin
      hi_acc_n = add_sum[WIDTH:1];
      lo_acc_n = {add_sum[0], lo_acc[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      cnt      <= '0;
      op_q     <= MULT;
      hi_acc   <= '0;
      lo_acc   <= '0;
      opnd     <= '0;
      neg_main <= 1'b0;
      neg_rem  <= 1'b0;
    end else begin
      busy <= (state_n != IDLE);
      done <= write_res;
      if (state == IDLE) begin
        if (mthi) hi <= wdata;
        if (mtlo) lo <= wdata;
      end
      if (start_ok) begin
        op_q   <= op_in;
        cnt    <= '0;
        hi_acc <= '0;
        if (op_is_div(op_in)) begin
          lo_acc <= a_mag;
          opnd   <= b_mag;
        end else begin
          lo_acc <= b_mag;
          opnd   <= a_mag;
        end
        // Divide by zero leaves quotient all ones and remainder |a|; suppressing the
        // quotient negation while still restoring a's sign yields LO=~0, HI=a.
        neg_main <= (a_neg ^ b_neg) & ~(op_is_div(op_in) & (b == '0));
        neg_rem  <= a_neg;
      end
      if (state == RUN) begin
        hi_acc <= hi_acc_n;
        lo_acc <= lo_acc_n;
        cnt    <= cnt + CW'(1);
      end
      if (write_res) begin
        hi <= fix_hi;
        lo <= fix_lo;
      end
    end
  end

endmodule

// File: tb/tb_mdu_hilo.sv
module tb_mdu_hilo;
  localparam int W = 32;

  logic         clk, rst, start, flush, mthi, mtlo, busy, done;
  logic [1:0]   op;
  logic [W-1:0] a, b, wdata, hi, lo;

  int total = 0;
  int bad   = 0;
  logic [31:0] mdl_hi, mdl_lo;

  mdu_hilo #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference arithmetic straight from the MIPS HI/LO rules.
  task automatic model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] eh, output logic [31:0] el);
    longint      sp;
    logic [63:0] up;
    int          sx, sy;
    sx = x; sy = y;
    case (o)
      2'b00: begin sp = longint'(sx) * longint'(sy); {eh, el} = sp; end
      2'b01: begin up = {32'd0, x} * {32'd0, y}; {eh, el} = up; end
      2'b10: begin
        if (y == 0) begin el = '1; eh = x; end
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin el = x; eh = '0; end
        else begin el = sx / sy; eh = sx % sy; end
      end
      default: begin
        if (y == 0) begin el = '1; eh = x; end
        else begin el = x / y; eh = x % y; end
      end
    endcase
  endtask

  // Caller is at a negedge; drives start for exactly one edge.
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 100);
    if (!done) chk("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic run_and_check(input string name, input logic [1:0] o,
                               input logic [31:0] x, input logic [31:0] y,
                               input logic [31:0] eh, input logic [31:0] el);
    int n;
    issue(o, x, y);
    chk({name, "_busy"}, {63'd0, busy}, 64'd1);
    wait_done(n);
    chk({name, "_latency"}, 64'(n), 64'(W + 1));
    chk({name, "_busy_at_done"}, {63'd0, busy}, 64'd0);
    chk({name, "_hi"}, {32'd0, hi}, {32'd0, eh});
    chk({name, "_lo"}, {32'd0, lo}, {32'd0, el});
    @(negedge clk);
    chk({name, "_done_pulse"}, {63'd0, done}, 64'd0);
    mdl_hi = eh; mdl_lo = el;
  endtask

  task automatic no_done_for(input string name, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk({name, "_no_done"}, 64'(seen), 64'd0);
  endtask

  initial begin
    vec_t vecs[6];
    logic [31:0] eh, el, rx, ry;
    logic [1:0]  ro;
    int n;

    vecs[0] = '{2'b00, 32'hFFFF_FFFD, 32'd7,          32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[1] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'hFFFF_FFFE, 32'h0000_0001};
    vecs[2] = '{2'b10, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{2'b11, 32'd100,       32'd7,          32'd2,         32'd14};
    vecs[4] = '{2'b11, 32'h0000_1234, 32'd0,          32'h0000_1234, 32'hFFFF_FFFF};
    vecs[5] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF,  32'd0,         32'h8000_0000};

    rst = 1'b1; start = 0; flush = 0; mthi = 0; mtlo = 0;
    op = '0; a = '0; b = '0; wdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_hi",   {32'd0, hi},   64'd0);
    chk("reset_lo",   {32'd0, lo},   64'd0);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    mdl_hi = '0; mdl_lo = '0;

    for (int i = 0; i < 6; i++)
      run_and_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);

    // MTHI then MULT flushed at RUN cycle 10; start/mthi while busy are ignored.
    mthi = 1'b1; wdata = 32'hAA;
    @(negedge clk);
    mthi = 1'b0;
    chk("mthi_hi", {32'd0, hi}, 64'hAA);
    mdl_hi = 32'hAA;
    issue(2'b00, 32'd5, 32'd9);
    start = 1'b1; op = 2'b11; mthi = 1'b1; wdata = 32'h55;
    @(negedge clk);
    start = 1'b0; mthi = 1'b0;
    repeat (8) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", {63'd0, busy}, 64'd0);
    chk("flush_done", {63'd0, done}, 64'd0);
    no_done_for("flush", 40);
    chk("flush_hi", {32'd0, hi}, {32'd0, mdl_hi});
    chk("flush_lo", {32'd0, lo}, {32'd0, mdl_lo});

    // Start together with flush in IDLE is dropped.
    start = 1'b1; flush = 1'b1; op = 2'b01; a = 32'd3; b = 32'd3;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("idle_flush_busy", {63'd0, busy}, 64'd0);
    no_done_for("idle_flush", 40);

    // MTLO with start in the same cycle: write visible, then overwritten by result.
    mtlo = 1'b1; wdata = 32'h5A5A;
    issue(2'b01, 32'd6, 32'd7);
    mtlo = 1'b0;
    chk("mtlo_same_cycle", {32'd0, lo}, 64'h5A5A);
    wait_done(n);
    chk("mtlo_then_result_lo", {32'd0, lo}, 64'd42);
    chk("mtlo_then_result_hi", {32'd0, hi}, 64'd0);
    @(negedge clk);

    // Reset mid-divide.
    issue(2'b10, 32'd1000, 32'd3);
    repeat (15) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_hi",   {32'd0, hi},   64'd0);
    chk("rst_mid_lo",   {32'd0, lo},   64'd0);
    chk("rst_mid_busy", {63'd0, busy}, 64'd0);
    no_done_for("rst_mid", 40);
    mdl_hi = '0; mdl_lo = '0;

    // Back-to-back: second start issued in the done cycle.
    issue(2'b11, 32'd50, 32'd8);
    wait_done(n);
    chk("b2b_first_lo", {32'd0, lo}, 64'd6);
    chk("b2b_first_hi", {32'd0, hi}, 64'd2);
    run_and_check("b2b_second", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd1);

    // Randomised operations against the reference model.
    for (int i = 0; i < 60; i++) begin
      ro = 2'($urandom_range(0, 3));
      rx = $urandom;
      ry = $urandom;
      case ($urandom_range(0, 7))
        0: ry = '0;
        1: ry = 32'($urandom_range(1, 20));
        2: ry = '1;
        3: rx = 32'h8000_0000;
        4: rx = 32'($urandom_range(0, 1000));
        default: ;
      endcase
      model(ro, rx, ry, eh, el);
      run_and_check($sformatf("rand%0d", i), ro, rx, ry, eh, el);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

endmodule
